mario_motion_ctrl: RTL and testbench
====================================

// Module: mario_motion_ctrl
// PURPOSE
//  Frame-rate motion/animation controller for the player character. Sequences
//  walk, jump and gravity once per video frame. Drives the sprite position and
//  the sprite-ROM select consumed by the VGA renderer, replacing free-running
//  delay counters with a frame_tick-locked state machine.
// PARAMETERS
//  POS_X_INIT   300  pos_x after reset
//  GROUND_Y     460  pos_y when standing (top edge of sprite)
//  X_MIN        143  left clamp bound (MARIO_CLAMP_EN only)
//  X_MAX        702  right clamp bound (MARIO_CLAMP_EN only)
//  V_INIT       15   launch speed, px/tick, applied upward
//  G            1    gravity, px/tick^2
//  V_MAX        15   terminal fall speed, px/tick
//  ANIM_PIXELS  15   px walked per walk-phase toggle
// PORTS
//  clk          in   1   pixel clock
//  rst          in   1   reset; asynchronous, active-high
//  frame_tick   in   1   1-cycle pulse once per frame (vertical blank)
//  btn_left     in   1   move left (level, debounced upstream)
//  btn_right    in   1   move right (level)
//  btn_jump     in   1   jump request (level)
//  pos_x        out  10  sprite left column, screen coords
//  pos_y        out  10  sprite top row, screen coords
//  sprite_sel   out  3   0 idle_R,1 idle_L,2 walk_R,3 walk_L,4 jump_R,5 jump_L
//  facing_left  out  1   1 = last horizontal intent was left
//  airborne     out  1   1 while in AIR state
// BEHAVIOUR
//  - Reset: pos_x=POS_X_INIT, pos_y=GROUND_Y, vel=0, state=IDLE, sprite_sel=0,
//    facing_left=0, airborne=0, walk_phase=0, anim_cnt=0, jump_prev=0.
//  - All state changes occur only on cycles with frame_tick=1. Buttons are sampled
//    on that cycle. Outputs are registered and valid the cycle after the tick.
//  - Horizontal intent: dir = right if btn_right&!btn_left, left if
//    btn_left&!btn_right, else none. Both pressed = none, and facing is held.
//  - Each tick with dir!=none: pos_x +/-1 (all states, including AIR),
//    facing_left updated, anim_cnt++. When anim_cnt reaches ANIM_PIXELS,
//    walk_phase toggles and anim_cnt clears in the same tick.
//  - Jump edge: jump_go = btn_jump & !jump_prev (jump_prev updated every tick).
//    Holding btn_jump never re-launches.
//  - FSM {IDLE, WALK, AIR}:
//    IDLE/WALK + jump_go: go to AIR. vel=-V_INIT, pos_y=GROUND_Y-V_INIT.
//    IDLE <-> WALK: select WALK if dir!=none, else IDLE. Entering IDLE clears
//    walk_phase and anim_cnt.
//    AIR: y_nxt = pos_y + vel (signed 11-bit), then vel=min(vel+G, V_MAX).
//    If y_nxt >= GROUND_Y: pos_y=GROUND_Y, vel=0, and next state is WALK/IDLE
//    by dir (jump_go on the landing tick is ignored). If y_nxt < 0, pos_y=0.
//    vel is signed 7-bit.
//  - sprite_sel: AIR -> jump by facing. WALK -> walk if walk_phase=0, jump if
//    walk_phase=1. IDLE -> idle by facing. airborne = (state==AIR).
//  - Async reset mid-jump returns immediately to the reset values.
// CONFIGURATION
//  MARIO_CLAMP_EN defined: pos_x saturates to [X_MIN, X_MAX]. A blocked step
//    leaves pos_x unchanged and does not advance anim_cnt. Facing still updates.
//  MARIO_CLAMP_EN undefined: pos_x wraps modulo 1024. X_MIN and X_MAX are unused.
// TESTING
//  1 rst pulse mid-run -> pos_x=300, pos_y=460, sprite_sel=0, airborne=0 at once.
//  2 btn_right held 15 ticks -> pos_x=315, sprite_sel 2 then 4 after tick 15,
//    back to 2 after tick 30. Release -> sprite_sel=0.
//  3 btn_jump pulse at rest -> pos_y=445, vel=-15. Apex pos_y=325 after
//    AIR ticks 15-16. Lands pos_y=460 on AIR tick 32. btn_jump held -> single jump.
//  4 btn_left+btn_right both held 10 ticks -> pos_x unchanged, anim_cnt=0,
//    sprite_sel keeps prior idle facing.
//  5 btn_left during jump, 20 ticks -> pos_x-20, sprite_sel=5 throughout AIR.
//  6 MARIO_CLAMP_EN, pos_x=702, btn_right 5 ticks -> pos_x=702, walk_phase
//    unchanged. Without the macro, from 1023 +1 -> pos_x=0.

Source files
------------

// File: rtl/mario_motion_ctrl.sv
// mario_motion_ctrl: frame-locked walk/jump/gravity controller; define MARIO_CLAMP_EN to saturate pos_x to [X_MIN, X_MAX] instead of wrapping
module mario_motion_ctrl #(
  parameter int POS_X_INIT  = 300,
  parameter int GROUND_Y    = 460,
  parameter int X_MIN       = 143,
  parameter int X_MAX       = 702,
  parameter int V_INIT      = 15,
  parameter int G           = 1,
  parameter int V_MAX       = 15,
  parameter int ANIM_PIXELS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [2:0] sprite_sel,
  output logic       facing_left,
  output logic       airborne
);
  localparam int AW = $clog2(ANIM_PIXELS + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WALK = 2'd1;
  localparam logic [1:0] S_AIR  = 2'd2;
  logic [1:0]        state_q, state_d;
  logic [9:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [6:0] vel_q, vel_d, vel_inc;
  logic              facing_q, facing_d, phase_q, phase_d, jump_prev_q, jump_prev_d;
  logic [AW-1:0]     anim_cnt_q, anim_cnt_d;
  logic [2:0]        sprite_q, sprite_d;
  logic              airborne_q, airborne_d;
  logic              go_r, go_l, step_ok, moving, jump_go;
  logic [9:0]        x_step;
  logic signed [10:0] y_nxt;
  logic [1:0]        ground_state;
  // Both buttons held cancel out so facing and position stay put.
  assign go_r    = btn_right & ~btn_left;
  assign go_l    = btn_left & ~btn_right;
  assign jump_go = btn_jump & ~jump_prev_q;
  assign x_step  = go_l ? pos_x_q - 10'd1 : pos_x_q + 10'd1;
`ifdef MARIO_CLAMP_EN
  assign step_ok = go_l ? (pos_x_q > 10'(X_MIN)) : (pos_x_q < 10'(X_MAX));
`else
  assign step_ok = 1'b1;
`endif
  assign moving       = (go_r | go_l) & step_ok;
  assign ground_state = (go_r | go_l) ? S_WALK : S_IDLE;
  assign y_nxt        = $signed({1'b0, pos_y_q}) + $signed({{4{vel_q[6]}}, vel_q});
  assign vel_inc      = vel_q + 7'(G);
  // Per-frame update of position, animation phase and FSM; holds between ticks.
  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    vel_d       = vel_q;
    facing_d    = facing_q;
    phase_d     = phase_q;
    anim_cnt_d  = anim_cnt_q;
    jump_prev_d = jump_prev_q;
    if (frame_tick) begin
      jump_prev_d = btn_jump;
      facing_d    = go_l ? 1'b1 : go_r ? 1'b0 : facing_q;
      pos_x_d     = moving ? x_step : pos_x_q;
      anim_cnt_d  = moving ? anim_cnt_q + AW'(1) : anim_cnt_q;
      if (moving && anim_cnt_q == AW'(ANIM_PIXELS - 1)) begin
        anim_cnt_d = '0;
        phase_d    = ~phase_q;
      end
      if (state_q != S_AIR) begin
        state_d = jump_go ? S_AIR : ground_state;
        vel_d   = jump_go ? 7'(-V_INIT) : vel_q;
        pos_y_d = jump_go ? 10'(GROUND_Y - V_INIT) : pos_y_q;
      end else if (y_nxt >= 11'(GROUND_Y)) begin
        state_d = ground_state;
        vel_d   = '0;
        pos_y_d = 10'(GROUND_Y);
      end else begin
        vel_d   = (vel_inc > 7'(V_MAX)) ? 7'(V_MAX) : vel_inc;
        pos_y_d = (y_nxt < 0) ? 10'd0 : y_nxt[9:0];
      end
      if (state_d == S_IDLE) begin
        phase_d    = 1'b0;
        anim_cnt_d = '0;
      end
    end
  end
  // Registered outputs derived from next state so they track the tick by one cycle.
  always_comb begin
    airborne_d = (state_d == S_AIR);
    sprite_d   = (state_d == S_AIR)  ? {2'b10, facing_d} :
                 (state_d == S_WALK) ? (phase_d ? {2'b10, facing_d} : {2'b01, facing_d}) :
                                       {2'b00, facing_d};
  end
  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pos_x_q     <= 10'(POS_X_INIT);
      pos_y_q     <= 10'(GROUND_Y);
      vel_q       <= '0;
      facing_q    <= 1'b0;
      phase_q     <= 1'b0;
      anim_cnt_q  <= '0;
      jump_prev_q <= 1'b0;
      sprite_q    <= 3'd0;
      airborne_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      vel_q       <= vel_d;
      facing_q    <= facing_d;
      phase_q     <= phase_d;
      anim_cnt_q  <= anim_cnt_d;
      jump_prev_q <= jump_prev_d;
      sprite_q    <= sprite_d;
      airborne_q  <= airborne_d;
    end
  end
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign sprite_sel  = sprite_q;
  assign facing_left = facing_q;
  assign airborne    = airborne_q;
endmodule

// File: tb/tb_mario_motion_ctrl.sv
// tb_mario_motion_ctrl: scoreboard bench for the frame-locked motion controller
module tb_mario_motion_ctrl;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] s;
    logic       f;
    logic       a;
  } exp_t;
  logic clk, rst, frame_tick, btn_left, btn_right, btn_jump;
  logic [9:0] pos_x, pos_y;
  logic [2:0] sprite_sel;
  logic facing_left, airborne;
  exp_t obs, e;
  exp_t sb[$];
  int vectors, miscompares;
  int m_x, m_y, m_v, m_st, m_f, m_ph, m_cnt, m_jp;
  mario_motion_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .pos_x(pos_x), .pos_y(pos_y), .sprite_sel(sprite_sel),
    .facing_left(facing_left), .airborne(airborne)
  );
  assign obs = {pos_x, pos_y, sprite_sel, facing_left, airborne};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic model_reset();
    m_x = 300; m_y = 460; m_v = 0; m_st = 0; m_f = 0; m_ph = 0; m_cnt = 0; m_jp = 0;
    sb.delete();
  endtask
  task automatic model_step(input bit l, input bit r, input bit j);
    int dir, yn;
    bit jgo, moved;
    exp_t x;
    dir = (r && !l) ? 1 : (l && !r) ? -1 : 0;
    jgo = j && (m_jp == 0);
    m_jp = j;
    moved = 0;
    if (dir != 0) begin
      m_f = (dir < 0);
`ifdef MARIO_CLAMP_EN
      if (m_x + dir >= 143 && m_x + dir <= 702) begin
        m_x = m_x + dir;
        moved = 1;
      end
`else
      m_x = (m_x + dir + 1024) % 1024;
      moved = 1;
`endif
    end
    if (moved) begin
      m_cnt++;
      if (m_cnt == 15) begin
        m_cnt = 0;
        m_ph = 1 - m_ph;
      end
    end
    if (m_st != 2) begin
      if (jgo) begin
        m_st = 2; m_v = -15; m_y = 445;
      end else m_st = (dir != 0) ? 1 : 0;
    end else begin
      yn = m_y + m_v;
      m_v = (m_v + 1 > 15) ? 15 : m_v + 1;
      if (yn >= 460) begin
        m_y = 460; m_v = 0; m_st = (dir != 0) ? 1 : 0;
      end else m_y = (yn < 0) ? 0 : yn;
    end
    if (m_st == 0) begin
      m_ph = 0; m_cnt = 0;
    end
    x.x = 10'(m_x);
    x.y = 10'(m_y);
    x.f = m_f[0];
    x.a = (m_st == 2);
    if (m_st == 2) x.s = 3'(4 + m_f);
    else if (m_st == 1) x.s = 3'((m_ph ? 4 : 2) + m_f);
    else x.s = 3'(m_f);
    sb.push_back(x);
  endtask
  // Buttons are held through two idle cycles before the tick, so non-tick cycles must not move anything.
  task automatic tick(input bit l, input bit r, input bit j);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_jump = j; frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    frame_tick = 1'b1;
    model_step(l, r, j);
    @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b0; frame_tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (obs !== {10'd300, 10'd460, 3'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_async: got x=%0d y=%0d sel=%0d f=%0b a=%0b want 300 460 0 0 0", obs.x, obs.y, obs.s, obs.f, obs.a);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (obs !== {10'd300, 10'd460, 3'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_held: got x=%0d y=%0d sel=%0d f=%0b a=%0b want 300 460 0 0 0", obs.x, obs.y, obs.s, obs.f, obs.a);
    end
    rst = 1'b0;
  endtask
  task automatic test_walk();
    for (int i = 1; i <= 31; i++) begin
      tick(i == 31 ? 1'b0 : 1'b0, i != 31, 1'b0);
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL walk[%0d]: got x=%0d y=%0d sel=%0d f=%0b a=%0b want x=%0d y=%0d sel=%0d f=%0b a=%0b", i, obs.x, obs.y, obs.s, obs.f, obs.a, e.x, e.y, e.s, e.f, e.a);
      end
      if (i == 14 || i == 15 || i == 30 || i == 31) begin
        vectors++;
        if (sprite_sel !== (i == 15 ? 3'd4 : i == 31 ? 3'd0 : 3'd2)) begin
          miscompares++;
          $display("FAIL walk_sel[%0d]: sprite_sel=%0d want %0d", i, sprite_sel, i == 15 ? 4 : i == 31 ? 0 : 2);
        end
      end
      if (i == 15) begin
        vectors++;
        if (pos_x !== 10'd315) begin
          miscompares++;
          $display("FAIL walk_x15: pos_x=%0d want 315", pos_x);
        end
      end
    end
  endtask
  task automatic test_jump();
    tick(1'b0, 1'b0, 1'b1);
    e = sb.pop_front();
    vectors++;
    if (obs !== e || pos_y !== 10'd445 || airborne !== 1'b1) begin
      miscompares++;
      $display("FAIL jump_launch: got y=%0d a=%0b sel=%0d want y=445 a=1 sel=%0d", obs.y, obs.a, obs.s, e.s);
    end
    for (int i = 1; i <= 32; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL jump[%0d]: got x=%0d y=%0d sel=%0d a=%0b want x=%0d y=%0d sel=%0d a=%0b", i, obs.x, obs.y, obs.s, obs.a, e.x, e.y, e.s, e.a);
      end
      if (i == 15 || i == 16) begin
        vectors++;
        if (pos_y !== 10'd325) begin
          miscompares++;
          $display("FAIL jump_apex[%0d]: pos_y=%0d want 325", i, pos_y);
        end
      end
      if (i == 31 || i == 32) begin
        vectors++;
        if (airborne !== (i == 31) || (i == 32 && pos_y !== 10'd460)) begin
          miscompares++;
          $display("FAIL jump_land[%0d]: airborne=%0b pos_y=%0d want airborne=%0b", i, airborne, pos_y, i == 31);
        end
      end
    end
  endtask
  task automatic test_jump_held();
    int launches;
    bit prev_air;
    launches = 0;
    prev_air = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL held[%0d]: got y=%0d a=%0b want y=%0d a=%0b", i, obs.y, obs.a, e.y, e.a);
      end
      if (airborne === 1'b1 && !prev_air) launches++;
      prev_air = airborne;
    end
    vectors++;
    if (launches != 1 || airborne !== 1'b0 || pos_y !== 10'd460) begin
      miscompares++;
      $display("FAIL held_single: launches=%0d airborne=%0b pos_y=%0d want 1 0 460", launches, airborne, pos_y);
    end
    tick(1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
  endtask
  task automatic test_both();
    int x0;
    tick(1'b1, 1'b0, 1'b0);
    e = sb.pop_front();
    tick(1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    x0 = m_x;
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      e = sb.pop_front();
      vectors++;
      if (obs !== e || pos_x !== 10'(x0) || sprite_sel !== 3'd1) begin
        miscompares++;
        $display("FAIL both[%0d]: got x=%0d sel=%0d f=%0b want x=%0d sel=1 f=1", i, obs.x, obs.s, obs.f, x0);
      end
    end
    for (int i = 1; i <= 15; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      e = sb.pop_front();
      vectors++;
      if (obs !== e || (i == 14 && sprite_sel !== 3'd2) || (i == 15 && sprite_sel !== 3'd4)) begin
        miscompares++;
        $display("FAIL both_walk[%0d]: got x=%0d sel=%0d want x=%0d sel=%0d", i, obs.x, obs.s, e.x, e.s);
      end
    end
    tick(1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
  endtask
  task automatic test_air_left();
    int x0;
    x0 = m_x;
    for (int i = 1; i <= 33; i++) begin
      tick(i <= 20, 1'b0, i == 1);
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL air_left[%0d]: got x=%0d y=%0d sel=%0d a=%0b want x=%0d y=%0d sel=%0d a=%0b", i, obs.x, obs.y, obs.s, obs.a, e.x, e.y, e.s, e.a);
      end
      if (i <= 32 && sprite_sel !== 3'd5) begin
        vectors++;
        miscompares++;
        $display("FAIL air_left_sel[%0d]: sprite_sel=%0d want 5", i, sprite_sel);
      end
      if (i == 20) begin
        vectors++;
        if (pos_x !== 10'(x0 - 20)) begin
          miscompares++;
          $display("FAIL air_left_x: pos_x=%0d want %0d", pos_x, x0 - 20);
        end
      end
    end
  endtask
  task automatic test_edge_x();
    int n;
    n = 0;
`ifdef MARIO_CLAMP_EN
    while (m_x != 702 && n < 1100) begin
      tick(1'b0, 1'b1, 1'b0);
      e = sb.pop_front();
      n++;
    end
    for (int i = 1; i <= 5; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      e = sb.pop_front();
      vectors++;
      if (obs !== e || pos_x !== 10'd702) begin
        miscompares++;
        $display("FAIL clamp[%0d]: got x=%0d sel=%0d want x=702 sel=%0d", i, obs.x, obs.s, e.s);
      end
    end
`else
    while (m_x != 1023 && n < 1100) begin
      tick(1'b0, 1'b1, 1'b0);
      e = sb.pop_front();
      n++;
      if (n % 97 == 0) begin
        vectors++;
        if (obs !== e) begin
          miscompares++;
          $display("FAIL run_right[%0d]: got x=%0d sel=%0d want x=%0d sel=%0d", n, obs.x, obs.s, e.x, e.s);
        end
      end
    end
    vectors++;
    if (pos_x !== 10'd1023) begin
      miscompares++;
      $display("FAIL wrap_pre: pos_x=%0d want 1023", pos_x);
    end
    tick(1'b0, 1'b1, 1'b0);
    e = sb.pop_front();
    vectors++;
    if (obs !== e || pos_x !== 10'd0) begin
      miscompares++;
      $display("FAIL wrap: got x=%0d sel=%0d want x=0 sel=%0d", obs.x, obs.s, e.s);
    end
`endif
  endtask
  task automatic test_async_reset();
    for (int i = 1; i <= 5; i++) begin
      tick(1'b0, 1'b1, i == 1);
      e = sb.pop_front();
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (obs !== {10'd300, 10'd460, 3'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_midjump: got x=%0d y=%0d sel=%0d f=%0b a=%0b want 300 460 0 0 0", obs.x, obs.y, obs.s, obs.f, obs.a);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(1'b0, 1'b0, 1'b1);
    e = sb.pop_front();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL post_reset_jump: got y=%0d a=%0b want y=%0d a=%0b", obs.y, obs.a, e.y, e.a);
    end
  endtask
  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_walk();
    test_jump();
    test_jump_held();
    test_both();
    test_air_left();
    test_edge_x();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
